// File: rtl/btn_pkg.sv
// Shared types for the push-button event decoder: FSM states and timer sizing.
// No logic of its own; no latency, no backpressure.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HELD1,
        LONG,
        GAP,
        HELD2
    } btn_state_t;

    // One spare bit above the larger limit so the saturating timer never wraps.
    function automatic int tmr_width(input int long_cycles, input int dclick_window);
        int m;
        m = (long_cycles > dclick_window) ? long_cycles : dclick_window;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Synchronises a raw pad and accepts a level change after DEBOUNCE_CYCLES stable samples.
// Latency 2 + DEBOUNCE_CYCLES for a clean edge; rise/fall are 1-cycle pulses; no backpressure.
module debounce_filter #(
    parameter int DEBOUNCE_CYCLES = 500,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          btn_s;
    logic [CW-1:0] cnt;

    assign btn_s = sync2 ^ ACTIVE_LOW;

    // Sync flops reset to the pad's released level so a held button is re-debounced.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (btn_s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= btn_s;
                rise  <= btn_s;
                fall  <= ~btn_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Debounced push-button classifier: press/release, single/double click and long press pulses.
// Events are registered one cycle after their trigger; free-running input, no backpressure.
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500,
    parameter int LONG_CYCLES     = 5000,
    parameter int DCLICK_WINDOW   = 2000,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press
);

    localparam int            TW        = tmr_width(LONG_CYCLES, DCLICK_WINDOW);
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(DCLICK_WINDOW - 1);

    btn_state_t    state;
    btn_state_t    state_nxt;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nxt;
    logic          single_nxt;
    logic          double_nxt;
    logic          long_nxt;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw),
        .level (btn_level),
        .rise  (press_pulse),
        .fall  (release_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            tmr          <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            state        <= state_nxt;
            tmr          <= tmr_nxt;
            single_click <= single_nxt;
            double_click <= double_nxt;
            long_press   <= long_nxt;
        end
    end

    // Edges are tested before timer expiry so an edge on the expiry cycle wins.
    always_comb begin
        state_nxt  = state;
        tmr_nxt    = (tmr == '1) ? tmr : tmr + 1'b1;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        case (state)
            IDLE: begin
                tmr_nxt = '0;
                if (press_pulse) state_nxt = HELD1;
            end
            HELD1: begin
                if (release_pulse) begin
                    state_nxt = GAP;
                    tmr_nxt   = '0;
                end else if (tmr == LONG_LAST) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end
            end
            LONG: begin
                tmr_nxt = '0;
                if (release_pulse) state_nxt = IDLE;
            end
            GAP: begin
                if (press_pulse) begin
                    state_nxt = HELD2;
                    tmr_nxt   = '0;
                end else if (tmr == GAP_LAST) begin
                    state_nxt  = IDLE;
                    single_nxt = 1'b1;
                end
            end
            HELD2: begin
                if (release_pulse) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                end else if (tmr == LONG_LAST) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
